// File: rtl/transaction_arbiter.sv
// Round-robin arbiter that hands a shared bus to one of REQUESTERS masters, enforcing bus-free gap,
// retries after arbitration loss and stuck-SCL recovery. Optional watchdog: TRANSACTION_TIMEOUT_EN.
module transaction_arbiter #(
  parameter int unsigned REQUESTERS     = 4,
  parameter int unsigned IDLE_GAP       = 5,
  parameter int unsigned RETRY_LIMIT    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [REQUESTERS-1:0] i_req,
  input  logic                  i_done,
  input  logic                  i_arbitration_lost,
  input  logic                  i_bus_busy,
  input  logic                  i_bus_clear,
  output logic [REQUESTERS-1:0] o_grant,
  output logic                  o_start,
  output logic [REQUESTERS-1:0] o_error,
  output logic                  o_recover
);

  localparam int unsigned PtrW   = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned GapW   = $clog2(IDLE_GAP + 1);
  localparam int unsigned RetryW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

  if (REQUESTERS < 2 || REQUESTERS > 8 || IDLE_GAP < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("transaction_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWaitFree,
    StStart,
    StActive,
    StRecover
  } state_e;

  state_e                r_state;
  logic [REQUESTERS-1:0] r_grant;
  logic [PtrW-1:0]       r_gidx;
  logic [PtrW-1:0]       r_ptr;
  logic [GapW-1:0]       r_gap;
  logic [RetryW-1:0]     r_retries;
  logic                  r_start;
  logic [REQUESTERS-1:0] r_error;
  logic                  r_recover;

`ifdef TRANSACTION_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdogW-1:0] r_wdog;
`endif

  logic                  w_pick_valid;
  logic [PtrW-1:0]       w_pick_idx;
  logic [REQUESTERS-1:0] w_pick_onehot;
  logic [PtrW-1:0]       w_idx;

  // Walk from the slot after the last owner, wrapping, and take the first requester found.
  always_comb begin
    w_pick_valid  = 1'b0;
    w_pick_idx    = '0;
    w_pick_onehot = '0;
    w_idx         = r_ptr;
    for (int k = 0; k < int'(REQUESTERS); k++) begin
      w_idx = (w_idx == PtrW'(REQUESTERS - 1)) ? '0 : w_idx + PtrW'(1);
      if (!w_pick_valid && i_req[w_idx]) begin
        w_pick_valid         = 1'b1;
        w_pick_idx           = w_idx;
        w_pick_onehot[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= PtrW'(REQUESTERS - 1);
      r_gap     <= '0;
      r_retries <= '0;
      r_start   <= 1'b0;
      r_error   <= '0;
      r_recover <= 1'b0;
`ifdef TRANSACTION_TIMEOUT_EN
      r_wdog    <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      r_error <= '0;
      case (r_state)
        StIdle: begin
          if (i_bus_clear) begin
            r_state   <= StRecover;
            r_recover <= 1'b1;
          end else if (w_pick_valid) begin
            r_grant   <= w_pick_onehot;
            r_gidx    <= w_pick_idx;
            r_gap     <= '0;
            r_retries <= '0;
            r_state   <= StWaitFree;
          end
        end

        StWaitFree: begin
          if (i_bus_clear) begin
            r_error   <= r_grant;
            r_grant   <= '0;
            r_ptr     <= r_gidx;
            r_state   <= StRecover;
            r_recover <= 1'b1;
          end else if (i_bus_busy) begin
            r_gap <= '0;
          end else if (r_gap == GapW'(IDLE_GAP - 1)) begin
            r_state <= StStart;
            r_start <= 1'b1;
          end else begin
            r_gap <= r_gap + GapW'(1);
          end
        end

        StStart: begin
          if (i_bus_clear) begin
            r_error   <= r_grant;
            r_grant   <= '0;
            r_ptr     <= r_gidx;
            r_state   <= StRecover;
            r_recover <= 1'b1;
          end else begin
            r_state <= StActive;
`ifdef TRANSACTION_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end
        end

        StActive: begin
          // Priority: stuck bus, then completion, then lost arbitration, then watchdog.
          if (i_bus_clear) begin
            r_error   <= r_grant;
            r_grant   <= '0;
            r_ptr     <= r_gidx;
            r_state   <= StRecover;
            r_recover <= 1'b1;
          end else if (i_done) begin
            r_grant <= '0;
            r_ptr   <= r_gidx;
            r_state <= StIdle;
          end else if (i_arbitration_lost) begin
            if (r_retries < RetryW'(RETRY_LIMIT)) begin
              r_retries <= r_retries + RetryW'(1);
              r_gap     <= '0;
              r_state   <= StWaitFree;
            end else begin
              r_error <= r_grant;
              r_grant <= '0;
              r_ptr   <= r_gidx;
              r_state <= StIdle;
            end
          end
`ifdef TRANSACTION_TIMEOUT_EN
          else if (r_wdog == WdogW'(TIMEOUT_CYCLES - 1)) begin
            r_error <= r_grant;
            r_grant <= '0;
            r_ptr   <= r_gidx;
            r_state <= StIdle;
          end else begin
            r_wdog <= r_wdog + WdogW'(1);
          end
`endif
        end

        StRecover: begin
          if (!i_bus_clear) begin
            r_state   <= StIdle;
            r_recover <= 1'b0;
          end
        end

        default: begin
          r_state   <= StIdle;
          r_grant   <= '0;
          r_recover <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant   = r_grant;
  assign o_start   = r_start;
  assign o_error   = r_error;
  assign o_recover = r_recover;

endmodule

// File: tb/tb_transaction_arbiter.sv
// Directed bench for transaction_arbiter: round-robin, gap timing, retries, recovery and reset.
module tb_transaction_arbiter;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [3:0] i_req;
  logic       i_done;
  logic       i_arbitration_lost;
  logic       i_bus_busy;
  logic       i_bus_clear;
  logic [3:0] o_grant;
  logic       o_start;
  logic [3:0] o_error;
  logic       o_recover;

  int n_vec = 0;
  int n_bad = 0;

  transaction_arbiter #(
    .REQUESTERS    (4),
    .IDLE_GAP      (5),
    .RETRY_LIMIT   (3),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk_in            (clk_in),
    .rst_n             (rst_n),
    .i_req             (i_req),
    .i_done            (i_done),
    .i_arbitration_lost(i_arbitration_lost),
    .i_bus_busy        (i_bus_busy),
    .i_bus_clear       (i_bus_clear),
    .o_grant           (o_grant),
    .o_start           (o_start),
    .o_error           (o_error),
    .o_recover         (o_recover)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // From a fresh WAIT_FREE entry with the bus free: start rises after the fifth edge, then ACTIVE.
  task automatic start_seq(input string tag);
    repeat (4) tick();
    check({tag, " pre-start"}, {3'b0, o_start}, 4'b0000);
    tick();
    check({tag, " start"}, {3'b0, o_start}, 4'b0001);
    tick();
    check({tag, " start drop"}, {3'b0, o_start}, 4'b0000);
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = '0;
    i_done = 1'b0;
    i_arbitration_lost = 1'b0;
    i_bus_busy = 1'b0;
    i_bus_clear = 1'b0;
    #12;
    check("reset grant", o_grant, 4'b0000);
    check("reset start", {3'b0, o_start}, 4'b0000);
    check("reset error", o_error, 4'b0000);
    check("reset recover", {3'b0, o_recover}, 4'b0000);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Round-robin from reset pointer 3: requester 1 first, then requester 2.
    i_req = 4'b0110;
    tick();
    check("rr first grant", o_grant, 4'b0010);
    start_seq("rr1");
    check("rr1 active grant", o_grant, 4'b0010);
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    check("done clears grant", o_grant, 4'b0000);
    tick();
    check("rr second grant", o_grant, 4'b0100);
    i_req = 4'b0000;
    start_seq("rr2");
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    check("rr2 done", o_grant, 4'b0000);

    // Busy during WAIT_FREE cycles 2-3 restarts the gap count; req dropped after grant.
    i_req = 4'b0001;
    tick();
    check("wrap grant", o_grant, 4'b0001);
    i_req = 4'b0000;
    tick();
    i_bus_busy = 1'b1;
    tick();
    tick();
    i_bus_busy = 1'b0;
    start_seq("busy gap");
    check("grant held", o_grant, 4'b0001);

    // Three retries keep the grant, the fourth loss abandons with an error pulse.
    for (int r = 0; r < 3; r++) begin
      i_arbitration_lost = 1'b1;
      tick();
      i_arbitration_lost = 1'b0;
      check("retry grant", o_grant, 4'b0001);
      check("retry no error", o_error, 4'b0000);
      start_seq("retry");
    end
    i_arbitration_lost = 1'b1;
    tick();
    i_arbitration_lost = 1'b0;
    check("loss error", o_error, 4'b0001);
    check("loss grant", o_grant, 4'b0000);
    tick();
    check("loss error pulse", o_error, 4'b0000);

    // Stuck bus for 10 cycles in ACTIVE.
    i_req = 4'b1000;
    tick();
    check("grant 3", o_grant, 4'b1000);
    i_req = 4'b0000;
    start_seq("clr");
    i_bus_clear = 1'b1;
    tick();
    check("clear error", o_error, 4'b1000);
    check("clear grant", o_grant, 4'b0000);
    check("clear recover", {3'b0, o_recover}, 4'b0001);
    repeat (9) tick();
    check("recover held", {3'b0, o_recover}, 4'b0001);
    check("recover error off", o_error, 4'b0000);
    i_bus_clear = 1'b0;
    tick();
    check("recover release", {3'b0, o_recover}, 4'b0000);

    // done and bus_clear together: bus_clear wins.
    i_req = 4'b0001;
    tick();
    check("grant 0 again", o_grant, 4'b0001);
    i_req = 4'b0000;
    start_seq("dc");
    i_done = 1'b1;
    i_bus_clear = 1'b1;
    tick();
    i_done = 1'b0;
    i_bus_clear = 1'b0;
    check("dc recover", {3'b0, o_recover}, 4'b0001);
    check("dc error", o_error, 4'b0001);
    tick();
    check("dc back idle", {3'b0, o_recover}, 4'b0000);

    // bus_clear in IDLE: recover with no error and no grant.
    i_req = 4'b0010;
    i_bus_clear = 1'b1;
    tick();
    check("idle clear recover", {3'b0, o_recover}, 4'b0001);
    check("idle clear no error", o_error, 4'b0000);
    tick();
    check("idle clear no grant", o_grant, 4'b0000);
    i_bus_clear = 1'b0;
    tick();
    check("idle clear exit", o_grant, 4'b0000);
    tick();
    check("grant after recover", o_grant, 4'b0010);
    i_req = 4'b0000;

    // done/arbitration_lost outside ACTIVE are ignored.
    i_done = 1'b1;
    i_arbitration_lost = 1'b1;
    tick();
    i_done = 1'b0;
    i_arbitration_lost = 1'b0;
    check("ignore done grant", o_grant, 4'b0010);
    check("ignore loss error", o_error, 4'b0000);
    repeat (3) tick();
    check("ignore pre-start", {3'b0, o_start}, 4'b0000);
    tick();
    check("ignore start", {3'b0, o_start}, 4'b0001);
    tick();

    // Asynchronous reset mid-ACTIVE.
    rst_n = 1'b0;
    #2;
    check("async reset grant", o_grant, 4'b0000);
    check("async reset error", o_error, 4'b0000);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    i_req = 4'b0011;
    tick();
    check("post-reset grant", o_grant, 4'b0001);
    i_req = 4'b0000;
    start_seq("wd");
    repeat (19) tick();
    check("wd 19 grant", o_grant, 4'b0001);
    check("wd 19 error", o_error, 4'b0000);
    tick();
`ifdef TRANSACTION_TIMEOUT_EN
    check("wd expiry error", o_error, 4'b0001);
    check("wd expiry grant", o_grant, 4'b0000);
`else
    check("no wd error", o_error, 4'b0000);
    check("no wd grant", o_grant, 4'b0001);
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    check("final done", o_grant, 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/transaction_arbiter.md
TRANSACTION_ARBITER -- requirements
Module: transaction_arbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 4: number of transaction requesters (2..8).
REQ-002 SHALL have parameter IDLE_GAP, default 5: consecutive bus-free clk_in cycles required before a start (tBUF).
REQ-003 SHALL have parameter RETRY_LIMIT, default 3: retries allowed after arbitration loss.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000: ACTIVE watchdog length, used only under REQ-025.
REQ-005 SHALL have port clk_in  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req  input  REQUESTERS  per-requester transaction request, level.
REQ-008 SHALL have port done  input  1  master pulse: transaction completed with STOP.
REQ-009 SHALL have port arbitration_lost  input  1  master pulse: multi-master arbitration lost.
REQ-010 SHALL have port bus_busy  input  1  bus occupied (START seen, no STOP yet).
REQ-011 SHALL have port bus_clear  input  1  SCL stuck low, from clock generator.
REQ-012 SHALL have ports grant (output, REQUESTERS, one-hot owner), start (output, 1, one-cycle begin pulse to master), error (output, REQUESTERS, one-cycle abandon pulse), recover (output, 1, high in RECOVER).

Function
REQ-013 SHALL implement states IDLE, WAIT_FREE, START, ACTIVE, RECOVER.
- IDLE: any req bit high -> WAIT_FREE; grant registered same edge; gap counter=0, retries=0.
- WAIT_FREE: bus_busy=1 clears gap counter; bus_busy=0 increments; at counter==IDLE_GAP-1 with bus_busy=0 -> START.
- START: start=1 this cycle only; next edge -> ACTIVE.
- ACTIVE: done -> IDLE, grant cleared, pointer=granted index; arbitration_lost -> REQ-016.
- RECOVER: recover=1; bus_clear=0 -> IDLE.
REQ-014 SHALL select round-robin: first req bit strictly after last-granted index, wrapping modulo REQUESTERS.
REQ-015 SHALL hold grant constant WAIT_FREE..ACTIVE; req deassertion after grant ignored.
REQ-016 On arbitration_lost in ACTIVE: retries<RETRY_LIMIT -> retries+1, gap counter=0, WAIT_FREE, same grant; else error pulse on granted bit, grant cleared, pointer advanced, IDLE.
REQ-017 Latency: req sampled at edge 0 with bus_busy=0 -> grant high after edge 0, start high for one cycle after edge IDLE_GAP.
REQ-018 bus_clear=1 in WAIT_FREE/START/ACTIVE SHALL pulse error on granted bit, clear grant, advance pointer, enter RECOVER next edge.
REQ-019 bus_clear=1 in IDLE SHALL enter RECOVER with no error pulse; no grant while bus_clear=1.
REQ-020 Same-cycle priority: bus_clear > done > arbitration_lost (> watchdog expiry).
REQ-021 done/arbitration_lost outside ACTIVE SHALL be ignored.
REQ-022 grant SHALL be zero or one-hot at all times; error SHALL be at most one-hot.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, grant=0, start=0, error=0, recover=0, counters=0, last-granted=REQUESTERS-1 (requester 0 first).
REQ-024 Reset mid-transaction SHALL abandon it without error pulse; first post-reset decision on first rising edge with rst_n=1.

Configuration
REQ-025 Macro TRANSACTION_TIMEOUT_EN defined: watchdog counts ACTIVE cycles from 0; reaching TIMEOUT_CYCLES without done -> error pulse on granted bit, grant cleared, pointer advanced, IDLE. Undefined: no watchdog logic, ACTIVE waits indefinitely.

Verification
REQ-026 req=4'b0110, bus_busy=0 -> grant=4'b0010 after edge 0, start pulse after edge 5; done -> then grant=4'b0100.
REQ-027 bus_busy=1 for cycles 2-3 of WAIT_FREE -> start delayed to 5 free cycles after bus_busy falls.
REQ-028 arbitration_lost four times for requester 0 -> three restarts with same grant, then error=4'b0001 one cycle, grant=0.
REQ-029 bus_clear=1 in ACTIVE for 10 cycles -> error pulse, recover high 10 cycles, IDLE after release; done+bus_clear same cycle -> RECOVER.
REQ-030 rst_n=0 mid-ACTIVE -> grant=0 asynchronously, no error; with TRANSACTION_TIMEOUT_EN, TIMEOUT_CYCLES=20, no done -> error after 20 ACTIVE cycles.
